hazard_scoreboard: RTL and testbench

Parametrised hazard unit for the in-order MIPS pipeline. It replaces fixed per-instruction-class forwarding equations with a Tuse/Tnew scoreboard. The block sits beside the decode stage and tracks every in-flight register writer in a shift register, one entry per post-decode stage. It drives the decode stall, the decode-stage and per-stage forward selects, and the multi-cycle MDU busy interlock.

---
 rtl/hazard_scoreboard.sv | 205 ++++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: Tuse/Tnew hazard unit for the in-order MIPS pipeline.
// A shift register holds one record per post-decode stage (entry 0 = EX,
// entry DEPTH-1 = WB). The decode stall, every forward select and the MDU
// busy interlock are derived combinationally from those records and the
// instruction currently sitting in decode.
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int DEPTH   = 3,
  parameter int TW      = 2,
  parameter int MDU_LAT = 5,
  parameter int CW      = 4,
  parameter int SW      = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [AW-1:0]           id_rs,
  input  logic [AW-1:0]           id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic [TW-1:0]           id_tuse_rs,
  input  logic [TW-1:0]           id_tuse_rt,
  input  logic [AW-1:0]           id_a3,
  input  logic [TW-1:0]           id_tnew,
  input  logic                    id_mdu_start,
  input  logic                    id_mdu_use,
  input  logic                    flush,
  output logic                    stall,
  output logic [SW-1:0]           fwd_rs_id,
  output logic [SW-1:0]           fwd_rt_id,
  output logic [(DEPTH-1)*SW-1:0] fwd_rs_stage,
  output logic [(DEPTH-1)*SW-1:0] fwd_rt_stage,
  output logic                    mdu_busy
);

  // Entry state. valid marks a pending register write; the source fields are
  // kept even for non-writers (stores, branches) because those instructions
  // still need their operands forwarded while they travel down the pipe.
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] use_rs_q, use_rs_d;
  logic [DEPTH-1:0] use_rt_q, use_rt_d;
  logic [AW-1:0]    a3_q   [DEPTH];
  logic [AW-1:0]    a3_d   [DEPTH];
  logic [AW-1:0]    rs_q   [DEPTH];
  logic [AW-1:0]    rs_d   [DEPTH];
  logic [AW-1:0]    rt_q   [DEPTH];
  logic [AW-1:0]    rt_d   [DEPTH];
  logic [TW-1:0]    tnew_q [DEPTH];
  logic [TW-1:0]    tnew_d [DEPTH];
  logic [CW-1:0]    mdu_cnt_q, mdu_cnt_d;

  logic             rs_hit, rt_hit;
  logic [SW-1:0]    rs_sel, rt_sel;
  logic [TW-1:0]    rs_hit_tnew, rt_hit_tnew;
  logic             data_stall, mdu_stall, load_id;

  // Find the youngest in-flight writer of each decode source; scanning from
  // the oldest entry down lets the youngest match overwrite older ones.
  always_comb begin
    rs_hit      = 1'b0;
    rs_sel      = '0;
    rs_hit_tnew = '0;
    rt_hit      = 1'b0;
    rt_sel      = '0;
    rt_hit_tnew = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && id_use_rs && (id_rs != '0) && (a3_q[i] == id_rs)) begin
        rs_hit      = 1'b1;
        rs_sel      = SW'(i + 1);
        rs_hit_tnew = tnew_q[i];
      end
      if (valid_q[i] && id_use_rt && (id_rt != '0) && (a3_q[i] == id_rt)) begin
        rt_hit      = 1'b1;
        rt_sel      = SW'(i + 1);
        rt_hit_tnew = tnew_q[i];
      end
    end
  end

  // Decode-stage forwarding, data/MDU interlocks and the stall itself.
  // Stall deliberately ignores flush so the front end sees a stable value.
  always_comb begin
    fwd_rs_id  = (rs_hit && (rs_hit_tnew == '0)) ? rs_sel : '0;
    fwd_rt_id  = (rt_hit && (rt_hit_tnew == '0)) ? rt_sel : '0;
    data_stall = (rs_hit && (rs_hit_tnew > id_tuse_rs)) ||
                 (rt_hit && (rt_hit_tnew > id_tuse_rt));
    mdu_stall  = id_mdu_use && (mdu_cnt_q != '0);
    stall      = id_valid && (data_stall || mdu_stall);
    mdu_busy   = (mdu_cnt_q != '0);
  end

  // Per-stage forwarding: the instruction in entry s looks only at older
  // entries s+1..DEPTH-1, and only the youngest of those matches decides.
  always_comb begin
    logic          hit_rs, hit_rt;
    logic [SW-1:0] sel_rs, sel_rt;
    logic [TW-1:0] tn_rs, tn_rt;
    hit_rs       = 1'b0;
    hit_rt       = 1'b0;
    sel_rs       = '0;
    sel_rt       = '0;
    tn_rs        = '0;
    tn_rt        = '0;
    fwd_rs_stage = '0;
    fwd_rt_stage = '0;
    for (int s = 0; s < DEPTH - 1; s++) begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      sel_rs = '0;
      sel_rt = '0;
      tn_rs  = '0;
      tn_rt  = '0;
      for (int j = DEPTH - 1; j > s; j--) begin
        if (valid_q[j] && use_rs_q[s] && (rs_q[s] != '0) && (a3_q[j] == rs_q[s])) begin
          hit_rs = 1'b1;
          sel_rs = SW'(j + 1);
          tn_rs  = tnew_q[j];
        end
        if (valid_q[j] && use_rt_q[s] && (rt_q[s] != '0) && (a3_q[j] == rt_q[s])) begin
          hit_rt = 1'b1;
          sel_rt = SW'(j + 1);
          tn_rt  = tnew_q[j];
        end
      end
      fwd_rs_stage[s*SW +: SW] = (hit_rs && (tn_rs == '0)) ? sel_rs : '0;
      fwd_rt_stage[s*SW +: SW] = (hit_rt && (tn_rt == '0)) ? sel_rt : '0;
    end
  end

  // Next entry state: advance every record one stage (ageing tnew toward 0),
  // load decode or a bubble into entry 0, and let flush wipe everything.
  always_comb begin
    load_id  = id_valid && !stall && !flush;
    valid_d  = valid_q;
    use_rs_d = use_rs_q;
    use_rt_d = use_rt_q;
    for (int i = 0; i < DEPTH; i++) begin
      a3_d[i]   = a3_q[i];
      rs_d[i]   = rs_q[i];
      rt_d[i]   = rt_q[i];
      tnew_d[i] = tnew_q[i];
    end
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i]  = valid_q[i-1];
      use_rs_d[i] = use_rs_q[i-1];
      use_rt_d[i] = use_rt_q[i-1];
      a3_d[i]     = a3_q[i-1];
      rs_d[i]     = rs_q[i-1];
      rt_d[i]     = rt_q[i-1];
      tnew_d[i]   = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
    valid_d[0]  = load_id && (id_a3 != '0);
    use_rs_d[0] = load_id && id_use_rs;
    use_rt_d[0] = load_id && id_use_rt;
    a3_d[0]     = id_a3;
    rs_d[0]     = id_rs;
    rt_d[0]     = id_rt;
    tnew_d[0]   = id_tnew;
    if (flush) begin
      valid_d  = '0;
      use_rs_d = '0;
      use_rt_d = '0;
    end
  end

  // MDU occupancy: reload on an issuing mult/div, otherwise count down.
  // Flush leaves it alone because the unit finishes the op regardless.
  always_comb begin
    if (id_mdu_start && id_valid && !stall) begin
      mdu_cnt_d = CW'(MDU_LAT);
    end else if (mdu_cnt_q != '0) begin
      mdu_cnt_d = mdu_cnt_q - CW'(1);
    end else begin
      mdu_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      use_rs_q  <= '0;
      use_rt_q  <= '0;
      mdu_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a3_q[i]   <= '0;
        rs_q[i]   <= '0;
        rt_q[i]   <= '0;
        tnew_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      use_rs_q  <= use_rs_d;
      use_rt_q  <= use_rt_d;
      mdu_cnt_q <= mdu_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        a3_q[i]   <= a3_d[i];
        rs_q[i]   <= rs_d[i];
        rt_q[i]   <= rt_d[i];
        tnew_q[i] <= tnew_d[i];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table with
// hand-derived outputs, followed by flush and reset corner sequences.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int TW    = 2;
  localparam int SW    = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    id_valid;
  logic [AW-1:0]           id_rs, id_rt, id_a3;
  logic                    id_use_rs, id_use_rt;
  logic [TW-1:0]           id_tuse_rs, id_tuse_rt, id_tnew;
  logic                    id_mdu_start, id_mdu_use, flush;
  logic                    stall, mdu_busy;
  logic [SW-1:0]           fwd_rs_id, fwd_rt_id;
  logic [(DEPTH-1)*SW-1:0] fwd_rs_stage, fwd_rt_stage;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard #(.AW(AW), .DEPTH(DEPTH), .TW(TW), .MDU_LAT(5), .CW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_tuse_rs   (id_tuse_rs),
    .id_tuse_rt   (id_tuse_rt),
    .id_a3        (id_a3),
    .id_tnew      (id_tnew),
    .id_mdu_start (id_mdu_start),
    .id_mdu_use   (id_mdu_use),
    .flush        (flush),
    .stall        (stall),
    .fwd_rs_id    (fwd_rs_id),
    .fwd_rt_id    (fwd_rt_id),
    .fwd_rs_stage (fwd_rs_stage),
    .fwd_rt_stage (fwd_rt_stage),
    .mdu_busy     (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs;
    logic        urs;
    logic [1:0]  trs;
    logic [4:0]  rt;
    logic        urt;
    logic [1:0]  trt;
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic        ms;
    logic        mu;
    logic        e_stall;
    logic [1:0]  e_rsid;
    logic [1:0]  e_rtid;
    logic [3:0]  e_srs;
    logic [3:0]  e_srt;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int v, input int rs, input int urs, input int trs,
                              input int rt, input int urt, input int trt,
                              input int a3, input int tnew, input int ms, input int mu,
                              input int e_stall, input int e_rsid, input int e_rtid,
                              input int e_srs, input int e_srt, input int e_busy);
    vec_t r;
    r.v = 1'(v);     r.rs = 5'(rs);   r.urs = 1'(urs); r.trs = 2'(trs);
    r.rt = 5'(rt);   r.urt = 1'(urt); r.trt = 2'(trt);
    r.a3 = 5'(a3);   r.tnew = 2'(tnew);
    r.ms = 1'(ms);   r.mu = 1'(mu);
    r.e_stall = 1'(e_stall); r.e_rsid = 2'(e_rsid); r.e_rtid = 2'(e_rtid);
    r.e_srs = 4'(e_srs);     r.e_srt = 4'(e_srt);   r.e_busy = 1'(e_busy);
    return r;
  endfunction

  task automatic drive(input vec_t r, input logic fl);
    id_valid     = r.v;
    id_rs        = r.rs;
    id_use_rs    = r.urs;
    id_tuse_rs   = r.trs;
    id_rt        = r.rt;
    id_use_rt    = r.urt;
    id_tuse_rt   = r.trt;
    id_a3        = r.a3;
    id_tnew      = r.tnew;
    id_mdu_start = r.ms;
    id_mdu_use   = r.mu;
    flush        = fl;
  endtask

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", nm, idx, act, exp_v);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t r);
    chk("stall",        idx, 8'(stall),        8'(r.e_stall));
    chk("fwd_rs_id",    idx, 8'(fwd_rs_id),    8'(r.e_rsid));
    chk("fwd_rt_id",    idx, 8'(fwd_rt_id),    8'(r.e_rtid));
    chk("fwd_rs_stage", idx, 8'(fwd_rs_stage), 8'(r.e_srs));
    chk("fwd_rt_stage", idx, 8'(fwd_rt_stage), 8'(r.e_srt));
    chk("mdu_busy",     idx, 8'(mdu_busy),     8'(r.e_busy));
  endtask

  vec_t nop_v;

  initial begin
    nop_v = mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0,0,0);

    // add $3 (tnew 1) then beq $3 (tuse 0)
    vecs.push_back(mk(1, 1,1,1, 2,1,1, 3,1, 0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1, 3,1,0, 0,0,0, 0,0, 0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(1, 3,1,0, 0,0,0, 0,0, 0,0, 0,2,0,0,0,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,3,0,0)); // beq in EX, add in WB
    vecs.push_back(nop_v);
    // lw $4 (tnew 2) then add $5,$4,$6 (tuse 1): one stall cycle
    vecs.push_back(mk(1, 1,1,1, 0,0,0, 4,2, 0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1, 4,1,1, 6,1,1, 5,1, 0,0, 1,0,0,0,0,0));
    vecs.push_back(mk(1, 4,1,1, 6,1,1, 5,1, 0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,3,0,0)); // add in EX, lw in WB
    vecs.push_back(nop_v);
    // zero register: writer of $0, reader of $0
    vecs.push_back(mk(1, 0,1,0, 0,0,0, 0,2, 0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1, 0,1,0, 0,1,0, 0,0, 0,0, 0,0,0,0,0,0));
    vecs.push_back(nop_v);
    // two writers of $5, then a reader: youngest wins in ID and in stages
    vecs.push_back(mk(1, 0,0,0, 0,0,0, 5,0, 0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1, 0,0,0, 0,0,0, 5,0, 0,0, 0,0,0,0,0,0));
    vecs.push_back(mk(1, 5,1,0, 5,1,0, 0,0, 0,0, 0,1,1,0,0,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,2,2,0));
    vecs.push_back(mk(0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,12,12,0));
    vecs.push_back(nop_v);
    // mult then mflo: five stall cycles, issues on the sixth
    vecs.push_back(mk(1, 8,1,1, 9,1,1, 0,0, 1,1, 0,0,0,0,0,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 0,0,0, 0,0,0, 10,1, 0,1, 1,0,0,0,0,1));
    vecs.push_back(mk(1, 0,0,0, 0,0,0, 10,1, 0,1, 0,0,0,0,0,0));
    vecs.push_back(nop_v);

    rst_n = 1'b0;
    drive(nop_v, 1'b0);
    repeat (2) @(negedge clk);
    chk_all(-1, nop_v);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k], 1'b0);
      #1;
      chk_all(k, vecs[k]);
    end

    // Flush during a load-use stall (lw tnew 3, add tuse 1 -> two stalls unflushed)
    @(negedge clk);
    drive(mk(1, 0,0,0, 0,0,0, 4,3, 0,0, 0,0,0,0,0,0), 1'b0);
    #1 chk("flush_lw_issue", 100, 8'(stall), 8'd0);
    @(negedge clk);
    drive(mk(1, 4,1,1, 0,0,0, 5,1, 0,0, 0,0,0,0,0,0), 1'b0);
    #1 chk("flush_pre_stall", 101, 8'(stall), 8'd1);
    @(negedge clk);
    drive(mk(1, 4,1,1, 0,0,0, 5,1, 0,0, 0,0,0,0,0,0), 1'b1);
    #1 chk("flush_stall_comb", 102, 8'(stall), 8'd1);
    @(negedge clk);
    drive(mk(1, 4,1,1, 0,0,0, 5,1, 0,0, 0,0,0,0,0,0), 1'b0);
    #1 chk("flush_post_stall", 103, 8'(stall), 8'd0);
    chk("flush_post_fwd", 103, 8'(fwd_rs_id), 8'd0);
    // Flush blocks a load and kills the add just issued
    @(negedge clk);
    drive(mk(1, 0,0,0, 0,0,0, 7,0, 0,0, 0,0,0,0,0,0), 1'b1);
    #1 chk("flush_wr_stall", 104, 8'(stall), 8'd0);
    @(negedge clk);
    drive(mk(1, 7,1,0, 5,1,0, 0,0, 0,0, 0,0,0,0,0,0), 1'b0);
    #1 chk("flush_noload_rs", 105, 8'(fwd_rs_id), 8'd0);
    chk("flush_kill_rt", 105, 8'(fwd_rt_id), 8'd0);
    chk("flush_kill_stall", 105, 8'(stall), 8'd0);

    // Reset in the middle of an MDU op
    @(negedge clk);
    drive(mk(1, 0,0,0, 0,0,0, 0,0, 1,1, 0,0,0,0,0,0), 1'b0);
    @(negedge clk);
    drive(nop_v, 1'b0);
    #1 chk("mdu_busy_pre_rst", 110, 8'(mdu_busy), 8'd1);
    drive(mk(1, 0,0,0, 0,0,0, 10,1, 0,1, 0,0,0,0,0,0), 1'b0);
    #1 chk("mdu_stall_pre_rst", 111, 8'(stall), 8'd1);
    rst_n = 1'b0;
    #1 chk("mdu_busy_in_rst", 112, 8'(mdu_busy), 8'd0);
    chk("mdu_stall_in_rst", 112, 8'(stall), 8'd0);
    drive(nop_v, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("mdu_busy_post_rst", 113, 8'(mdu_busy), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
